// File: rtl/overlay_pkg.sv
// Shared types for the overlay fetch path: ABGR4444 pixel layout and fetch FSM states.
package overlay_pkg;
   localparam int OVL_WIDTH  = 540;
   localparam int OVL_HEIGHT = 720;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] g;
      logic [3:0] r;
   } overlay_px_t;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;
endpackage

// File: rtl/overlay_fifo.sv
// Small synchronous word FIFO with flush; count reflects same-cycle push and pop.
module overlay_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [31:0]            din,
   output logic [31:0]            dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_pop;

   assign empty  = (count == '0);
   assign do_pop = pop & ~empty;
   assign dout   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && !do_pop && !flush && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/overlay_fetch.sv
// Streams the overlay bitmap from SDRAM in raster order and unpacks it into one
// ABGR4444 pixel per active video pixel, prefetching words into a small FIFO.
module overlay_fetch
   import overlay_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int FRAME_WORDS = 194400,
   parameter int ADDR_W      = 24
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              ce_pix,
   input  logic              hblank,
   input  logic              vblank,
   input  logic              vsync,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_data,
   output logic [3:0]        bg_r,
   output logic [3:0]        bg_g,
   output logic [3:0]        bg_b,
   output logic [3:0]        bg_a,
   output logic              underflow
);
   localparam int CNT_W = $clog2(FRAME_WORDS + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t     state, state_n;
   logic             vsync_q, frame_start, flush;
   logic             accept, keep, discard;
   logic             half_sel, pix_go, pop;
   logic [CNT_W-1:0] word_cnt;
   logic [OCC_W-1:0] fifo_count;
   logic [31:0]      fifo_dout;
   logic             fifo_empty;
   overlay_px_t      px, pix;

   assign frame_start = ce_pix & vsync & ~vsync_q;
   assign flush       = frame_start | ~enable;
   assign accept      = (state == F_WAIT) & mem_ack;
   assign keep        = accept & ~discard & ~flush;
   assign pix_go      = ce_pix & enable & ~(hblank | vblank) & ~frame_start;
   assign pop         = pix_go & ~fifo_empty & half_sel;
   assign px          = half_sel ? fifo_dout[31:16] : fifo_dout[15:0];

   assign bg_r = pix.r;
   assign bg_g = pix.g;
   assign bg_b = pix.b;
   assign bg_a = pix.a;

   overlay_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (keep),
      .pop   (pop),
      .flush (flush),
      .din   (mem_data),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= F_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      mem_req = 1'b0;
      case (state)
         F_IDLE:
            if (enable && !discard && word_cnt < CNT_W'(FRAME_WORDS) &&
                fifo_count < OCC_W'(FIFO_DEPTH))
               state_n = F_REQ;
         F_REQ: begin
            mem_req = 1'b1;
            state_n = F_WAIT;
         end
         F_WAIT:
            if (mem_ack) state_n = F_IDLE;
         default: state_n = F_IDLE;
      endcase
   end

   // A flush while a request is in flight poisons its ack; an ack landing in the
   // flush cycle itself is simply not pushed, so discard is never left dangling.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vsync_q  <= 1'b0;
         mem_addr <= '0;
         word_cnt <= '0;
         discard  <= 1'b0;
      end else begin
         if (ce_pix) vsync_q <= vsync;
         if (frame_start) begin
            mem_addr <= '0;
            word_cnt <= '0;
         end else if (keep) begin
            mem_addr <= mem_addr + ADDR_W'(2);
            word_cnt <= word_cnt + CNT_W'(1);
         end
         if (accept)                         discard <= 1'b0;
         else if (flush && state != F_IDLE)  discard <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         half_sel  <= 1'b0;
         underflow <= 1'b0;
         pix       <= '0;
      end else begin
         if (frame_start) begin
            half_sel  <= 1'b0;
            underflow <= 1'b0;
         end else if (pix_go) begin
            if (!fifo_empty) half_sel  <= ~half_sel;
            else             underflow <= 1'b1;
         end
         if (!enable)     pix <= '0;
         else if (pix_go) pix <= fifo_empty ? overlay_px_t'('0) : px;
      end
   end
endmodule

// File: tb/tb_overlay_fetch.sv
// Directed bench for overlay_fetch: fill, unpack, underflow, frame restart, frame length, disable/reset.
module tb_overlay_fetch;
   import overlay_pkg::*;

   localparam int FW = 8;

   logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, ce_pix = 1'b1;
   logic        hblank = 1'b1, vblank = 1'b1, vsync = 1'b0;
   logic        mem_req, mem_ack = 1'b0;
   logic [23:0] mem_addr;
   logic [31:0] mem_data = '0;
   logic [3:0]  bg_r, bg_g, bg_b, bg_a;
   logic        underflow;
   logic [15:0] bg;

   int          n_chk = 0, n_fail = 0;
   int          ack_lat = 3, ack_cnt = 0, n_acks = 0;
   logic [23:0] ack_addr = '0;
   logic [23:0] req_log [$];

   assign bg = {bg_a, bg_b, bg_g, bg_r};

   overlay_fetch #(.FIFO_DEPTH(4), .FRAME_WORDS(FW), .ADDR_W(24)) dut (
      .clock(clock), .reset(reset), .enable(enable), .ce_pix(ce_pix),
      .hblank(hblank), .vblank(vblank), .vsync(vsync),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a), .underflow(underflow)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [23:0] a);
      return 32'h8421_F0A5 ^ {a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] log_at(input int i);
      if (i < req_log.size()) return 32'(req_log[i]);
      return 32'hFFFF_FFFF;
   endfunction

   // Memory model: latency latched per request; not reset, so a late ack can outlive a DUT reset.
   always @(posedge clock) begin
      mem_ack <= 1'b0;
      if (mem_req) begin
         ack_cnt  <= ack_lat;
         ack_addr <= mem_addr;
      end else if (ack_cnt > 0) begin
         ack_cnt <= ack_cnt - 1;
         if (ack_cnt == 1) begin
            mem_ack  <= 1'b1;
            mem_data <= word_at(ack_addr);
            n_acks   <= n_acks + 1;
         end
      end
   end

   always @(negedge clock) if (mem_req) req_log.push_back(mem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic frame_pulse();
      hblank = 1'b1; vblank = 1'b1; vsync = 1'b1;
      step(2);
      vsync = 1'b0;
      step(2);
      vblank = 1'b0;
   endtask

   initial begin
      int          k, c, nreq, nack;
      logic        gap;
      logic [31:0] w;
      logic [15:0] exp_px;

      step(3);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_bg", bg, 0);
      chk("rst_uf", underflow, 0);
      reset = 1'b0;
      step(2);

      // Fill: four words, addresses 0..6, then stop on a full FIFO.
      frame_pulse();
      req_log.delete();
      enable = 1'b1;
      step(40);
      chk("fill_nreq", req_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("fill_addr", log_at(i), 2 * i);
      chk("fill_cnt", dut.u_fifo.count, 4);

      // Unpack 0x8421_F0A5: low half first.
      hblank = 1'b0;
      step(1);
      chk("px1", bg, 16'hF0A5);
      chk("px1_r", bg_r, 4'h5);
      chk("px1_a", bg_a, 4'hF);
      step(1);
      hblank = 1'b1;
      chk("px2", bg, 16'h8421);
      chk("pop_cnt", dut.u_fifo.count, 3);

      // Slow memory with continuous active pixels: gaps must be black with underflow, no skipped pixel.
      step(10);
      ack_lat = 40;
      k = 0;
      gap = 1'b0;
      hblank = 1'b0;
      for (int cyc = 0; cyc < 400 && k < 14; cyc++) begin
         step(1);
         if (bg == 16'h0) begin
            gap = 1'b1;
            chk("gap_uf", underflow, 1);
         end else begin
            w = word_at(24'(2 + 2 * (k / 2)));
            exp_px = (k % 2 == 1) ? w[31:16] : w[15:0];
            chk("stream_px", bg, exp_px);
            k++;
         end
      end
      hblank = 1'b1;
      chk("stream_done", k, 14);
      chk("gap_seen", gap, 1);
      step(3);
      w = word_at(24'd14);
      chk("blank_hold", bg, w[31:16]);

      // Frame length: exactly FW requests, last at 14, none afterwards.
      step(40);
      chk("fw_nreq", req_log.size(), FW);
      chk("fw_last", log_at(FW - 1), 14);
      chk("uf_sticky", underflow, 1);

      // New frame clears underflow and refetches from 0.
      ack_lat = 3;
      req_log.delete();
      frame_pulse();
      chk("vs_uf_clr", underflow, 0);
      step(40);

      // Vsync while waiting on addr 8: its ack must be dropped.
      ack_lat = 20;
      hblank = 1'b0;
      step(2);
      hblank = 1'b1;
      step(4);
      chk("vs_old_req", log_at(4), 8);
      chk("vs_in_wait", 32'(dut.state), 32'(F_WAIT));
      ack_lat = 3;
      req_log.delete();
      frame_pulse();
      step(60);
      chk("vs_nreq", req_log.size(), 4);
      chk("vs_first", log_at(0), 0);
      hblank = 1'b0;
      step(1);
      hblank = 1'b1;
      chk("vs_px", bg, 16'hF0A5);

      // Disable mid-line.
      ack_lat = 10;
      hblank = 1'b0;
      step(2);
      enable = 1'b0;
      step(1);
      chk("dis_bg", bg, 0);
      chk("dis_empty", dut.u_fifo.empty, 1);
      hblank = 1'b1;
      nreq = req_log.size();
      step(20);
      chk("dis_noreq", req_log.size(), nreq);

      // Reset while in F_WAIT, then a stray ack arrives.
      enable = 1'b1;
      c = 0;
      while (req_log.size() == nreq && c < 30) begin
         step(1);
         c++;
      end
      chk("rst_pre_req", req_log.size(), nreq + 1);
      reset = 1'b1;
      enable = 1'b0;
      #1;
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_state", 32'(dut.state), 32'(F_IDLE));
      step(2);
      reset = 1'b0;
      nack = n_acks;
      step(15);
      chk("stray_seen", n_acks > nack, 1);
      chk("stray_cnt", dut.u_fifo.count, 0);
      chk("stray_addr", mem_addr, 0);
      chk("stray_state", 32'(dut.state), 32'(F_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
